// File: rtl/da_input_sequencer.sv
// Purpose: input sequencer for the DA adaptive filter. It keeps the 4-tap sample delay line and
//          steps the one-hot slot code t through a 6-slot frame for each accepted sample.
// Latency: an accept at edge k shows Z1 and the new x1 in cycle k+1, and frame_done in cycle k+6.
//          frame_cnt updates at the edge that ends T6.
// Backpressure: in_ready is high only in IDLE or T6 with flush low. A refused sample stays with
//               the producer.
// Ports: clk/r (async active-low reset), in_valid/in_data/in_ready (sample handshake),
//        flush (sync clear), t (slot code), x1..x4 (taps, x1 newest), frame_done, frame_cnt.
module da_input_sequencer #(
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   r,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   input  logic                   flush,
   output logic [5:0]             t,
   output logic [7:0]             x1,
   output logic [7:0]             x2,
   output logic [7:0]             x3,
   output logic [7:0]             x4,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_Z1, S_Z2, S_Z3, S_Z4, S_T5, S_T6
   } state_t;

   state_t                 state_q, state_d;
   logic [5:0]             t_q, t_d;
   logic [7:0]             x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
   logic                   frame_done_q, frame_done_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   accept;

   assign in_ready = ((state_q == S_IDLE) || (state_q == S_T6)) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      x3_d        = x3_q;
      x4_d        = x4_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         S_IDLE:  state_d = accept ? S_Z1 : S_IDLE;
         S_Z1:    state_d = S_Z2;
         S_Z2:    state_d = S_Z3;
         S_Z3:    state_d = S_Z4;
         S_Z4:    state_d = S_T5;
         S_T5:    state_d = S_T6;
         S_T6:    state_d = accept ? S_Z1 : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         x4_d = x3_q;
         x3_d = x2_q;
         x2_d = x1_q;
         x1_d = in_data;
      end

      // A T6 cycle already on the outputs still counts even if flush arrives in it.
      if ((state_q == S_T6) && (frame_cnt_q != {FRAME_CNT_W{1'b1}}))
         frame_cnt_d = frame_cnt_q + 1'b1;

      // accept is already blocked by flush, so only the clear needs overriding here.
      if (flush) begin
         state_d = S_IDLE;
         x1_d    = 8'h00;
         x2_d    = 8'h00;
         x3_d    = 8'h00;
         x4_d    = 8'h00;
      end

      // t and frame_done are decoded from the next state, so they line up with the state register.
      case (state_d)
         S_Z1:    t_d = 6'b000001;
         S_Z2:    t_d = 6'b000010;
         S_Z3:    t_d = 6'b000100;
         S_Z4:    t_d = 6'b001000;
         S_T5:    t_d = 6'b010000;
         default: t_d = 6'b100000;   // T6 and IDLE both present the T6 code
      endcase
      frame_done_d = (state_d == S_T6);
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_q      <= S_IDLE;
         t_q          <= 6'b100000;
         x1_q         <= 8'h00;
         x2_q         <= 8'h00;
         x3_q         <= 8'h00;
         x4_q         <= 8'h00;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         t_q          <= t_d;
         x1_q         <= x1_d;
         x2_q         <= x2_d;
         x3_q         <= x3_d;
         x4_q         <= x4_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign t          = t_q;
   assign x1         = x1_q;
   assign x2         = x2_q;
   assign x3         = x3_q;
   assign x4         = x4_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
